soc_system_onchip_ram_pipelined: RTL



---
 rtl/soc_system_onchip_ram_pipelined.sv | 77 +++++++
 1 files changed

// File: rtl/soc_system_onchip_ram_pipelined.sv
// soc_system_onchip_ram_pipelined: Avalon-MM single-port RAM with pipelined reads, write protection and zero-fill engine
module soc_system_onchip_ram_pipelined #(
    parameter int DATA_W = 16,
    parameter int DEPTH = 128,
    parameter int READ_LATENCY = 2,
    parameter bit WRITE_PROTECT = 1'b1,
    parameter bit CLEAR_ON_RESET = 1'b0,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [ADDR_W-1:0]   address,
    input  logic [DATA_W/8-1:0] byteenable,
    input  logic                chipselect,
    input  logic                read,
    input  logic                write,
    input  logic [DATA_W-1:0]   writedata,
    input  logic                debugaccess,
    input  logic                clear_req,
    output logic [DATA_W-1:0]   readdata,
    output logic                readdatavalid,
    output logic                waitrequest,
    output logic                clear_busy
);
    typedef enum logic {IDLE, CLEAR} state_t;
    state_t state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic start_q;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] s1_q, out_q;
    logic s1_vld_q, out_vld_q;
    logic accept, wr_en, rd_en;

    assign accept = reset_n && chipselect && !waitrequest;
    assign wr_en = accept && write && (!WRITE_PROTECT || debugaccess);
    assign rd_en = accept && read && !write;
    // start_q holds off commands between reset release and the automatic clear
    assign waitrequest = state_q == CLEAR || start_q;
    assign clear_busy = state_q == CLEAR;
    assign readdata = READ_LATENCY == 1 ? s1_q : out_q;
    assign readdatavalid = READ_LATENCY == 1 ? s1_vld_q : out_vld_q;

    always_comb begin
        state_d = state_q;
        cnt_d = cnt_q;
        state_d = state_q == IDLE ? ((clear_req || start_q) ? CLEAR : IDLE) : (&cnt_q ? IDLE : CLEAR);
        cnt_d = state_q == CLEAR ? cnt_q + 1'b1 : '0;
    end

    always_ff @(posedge clk) begin
        if (state_q == CLEAR)
            mem[cnt_q] <= '0;
        else if (wr_en)
            for (int i = 0; i < DATA_W / 8; i++)
                if (byteenable[i]) mem[address][8*i +: 8] <= writedata[8*i +: 8];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q <= '0;
            start_q <= CLEAR_ON_RESET;
            s1_q <= '0;
            s1_vld_q <= 1'b0;
            out_q <= '0;
            out_vld_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q <= cnt_d;
            start_q <= 1'b0;
            s1_vld_q <= rd_en;
            if (rd_en) s1_q <= mem[address];
            out_vld_q <= s1_vld_q;
            if (s1_vld_q) out_q <= s1_q;
        end
    end
endmodule
